// File: rtl/dp_ram_init_bypass.sv
// ---------------------------------------------------------------------------
// dp_ram_init_bypass
//   Single-clock 1R1W RAM with a self-clearing init sequencer, read-during-
//   write bypass with bit-enable merge, 1- or 2-cycle registered read latency
//   and a read-valid flag. Contents are zeroed (INIT_VALUE) after reset
//   without software help.
//
// Ports
//   CLK       clock, rising edge
//   RST       asynchronous reset, active high
//   AA/CEA    read address / read enable
//   AB/CEB    write address / write enable
//   DB/BWB    write data / per-bit write enable
//   QA        registered read data, holds when no read completes
//   QA_VALID  one-cycle pulse per accepted read, READ_LATENCY cycles after CEA
//   READY     1 once init is done; CEA/CEB are ignored while 0
// ---------------------------------------------------------------------------
module dp_ram_init_bypass #(
    parameter int unsigned ADDR_WIDTH    = 6,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned BYPASS        = 1,
    parameter int unsigned INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] AA,
    input  logic                  CEA,
    input  logic [ADDR_WIDTH-1:0] AB,
    input  logic                  CEB,
    input  logic [DATA_WIDTH-1:0] DB,
    input  logic [DATA_WIDTH-1:0] BWB,
    output logic [DATA_WIDTH-1:0] QA,
    output logic                  QA_VALID,
    output logic                  READY
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_RUN;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0]   cnt_d;
    logic                    ready_d;
    logic                    init_we_c;

    logic                    rd_acc_c;
    logic                    wr_acc_c;
    logic [DATA_WIDTH-1:0]   wr_merged_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // State, init counter and READY registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            READY   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            READY   <= ready_d;
        end
    end

    // Next-state: INIT sweeps every address once, then RUN forever
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we_c = 1'b0;
        ready_d   = 1'b0;
        case (state_q)
            S_INIT: begin
                init_we_c = 1'b1;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
        ready_d = (state_d == S_RUN);
    end

    // User accesses are only honoured once READY is visible
    assign rd_acc_c    = READY & CEA;
    assign wr_acc_c    = READY & CEB;
    assign wr_merged_c = (DB & BWB) | (mem[AB] & ~BWB);

    // Same-cycle same-address read sees the merged word only when bypassing
    always_comb begin
        rd_word_c = mem[AA];
        if ((BYPASS != 0) && wr_acc_c && (AA == AB)) begin
            rd_word_c = wr_merged_c;
        end
    end

    // Array write port; contents deliberately carry no reset
    always_ff @(posedge CLK) begin
        if (init_we_c) begin
            mem[cnt_q] <= INIT_VALUE;
        end else if (wr_acc_c) begin
            mem[AB] <= wr_merged_c;
        end
    end

    // Read output pipeline
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    QA       <= '0;
                    QA_VALID <= 1'b0;
                end else begin
                    QA_VALID <= rd_acc_c;
                    if (rd_acc_c) begin
                        QA <= rd_word_c;
                    end
                end
            end
        end else if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s1_data;
            logic                  s1_valid;

            // Extra data+valid stage; writes after the sample are not forwarded
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    s1_data  <= '0;
                    s1_valid <= 1'b0;
                    QA       <= '0;
                    QA_VALID <= 1'b0;
                end else begin
                    s1_valid <= rd_acc_c;
                    if (rd_acc_c) begin
                        s1_data <= rd_word_c;
                    end
                    QA_VALID <= s1_valid;
                    if (s1_valid) begin
                        QA <= s1_data;
                    end
                end
            end
        end else begin : g_bad_latency
            $error("dp_ram_init_bypass: READ_LATENCY must be 1 or 2");
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_init_bypass.sv
// ---------------------------------------------------------------------------
// tb_dp_ram_init_bypass
//   Two instances share one stimulus stream: u_a (latency 1, bypass on) and
//   u_b (latency 2, bypass off). A behavioural model keeps the word array and
//   a list of due results per instance; every negedge the outputs are
//   compared against it. Literal checks pin the directed scenarios.
// ---------------------------------------------------------------------------
module tb_dp_ram_init_bypass;

    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int DEPTH = 64;
    localparam int LAT_A = 1;
    localparam int LAT_B = 2;
    localparam logic [DW-1:0] INITV = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] aa, ab;
    logic          cea, ceb;
    logic [DW-1:0] db, bwb;
    logic [DW-1:0] qa_a, qa_b;
    logic          v_a, v_b, rdy_a, rdy_b;

    always #5 clk = ~clk;

    dp_ram_init_bypass #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT_A), .BYPASS(1),
        .INIT_ON_RESET(1), .INIT_VALUE(INITV)
    ) u_a (
        .CLK(clk), .RST(rst), .AA(aa), .CEA(cea), .AB(ab), .CEB(ceb),
        .DB(db), .BWB(bwb), .QA(qa_a), .QA_VALID(v_a), .READY(rdy_a)
    );

    dp_ram_init_bypass #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT_B), .BYPASS(0),
        .INIT_ON_RESET(1), .INIT_VALUE(INITV)
    ) u_b (
        .CLK(clk), .RST(rst), .AA(aa), .CEA(cea), .AB(ab), .CEB(ceb),
        .DB(db), .BWB(bwb), .QA(qa_b), .QA_VALID(v_b), .READY(rdy_b)
    );

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } res_t;

    res_t          q_a[$];
    res_t          q_b[$];
    res_t          r;
    logic [DW-1:0] mem_m [DEPTH];
    int            edge_no   = 0;
    int            since_rst = 0;
    bit            m_ready   = 1'b0;
    bit            m_rd, m_wr;
    logic [DW-1:0] m_old, m_merged;
    logic [DW-1:0] exp_qa_a = '0, exp_qa_b = '0;
    bit            exp_v_a = 1'b0, exp_v_b = 1'b0, exp_ready = 1'b0;

    always @(posedge clk) begin
        edge_no++;
        if (rst) begin
            since_rst = 0;
            m_ready   = 1'b0;
            q_a.delete();
            q_b.delete();
            exp_qa_a  = '0;
            exp_qa_b  = '0;
            exp_v_a   = 1'b0;
            exp_v_b   = 1'b0;
            exp_ready = 1'b0;
        end else begin
            m_rd     = m_ready && cea;
            m_wr     = m_ready && ceb;
            m_old    = mem_m[aa];
            m_merged = (db & bwb) | (mem_m[ab] & ~bwb);
            if (!m_ready) begin
                mem_m[since_rst] = INITV;
                since_rst++;
                if (since_rst == DEPTH) m_ready = 1'b1;
            end else begin
                if (m_rd) begin
                    r.due  = edge_no + LAT_A - 1;
                    r.data = (m_wr && aa == ab) ? m_merged : m_old;
                    q_a.push_back(r);
                    r.due  = edge_no + LAT_B - 1;
                    r.data = m_old;
                    q_b.push_back(r);
                end
                if (m_wr) mem_m[ab] = m_merged;
            end
            exp_v_a = 1'b0;
            if (q_a.size() > 0 && q_a[0].due == edge_no) begin
                exp_v_a  = 1'b1;
                exp_qa_a = q_a[0].data;
                void'(q_a.pop_front());
            end
            exp_v_b = 1'b0;
            if (q_b.size() > 0 && q_b[0].due == edge_no) begin
                exp_v_b  = 1'b1;
                exp_qa_b = q_b[0].data;
                void'(q_b.pop_front());
            end
            exp_ready = m_ready;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("ready_a", DW'(rdy_a), DW'(exp_ready));
            chk("ready_b", DW'(rdy_b), DW'(exp_ready));
            chk("valid_a", DW'(v_a), DW'(exp_v_a));
            chk("valid_b", DW'(v_b), DW'(exp_v_b));
            chk("qa_a", qa_a, exp_qa_a);
            chk("qa_b", qa_b, exp_qa_b);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cea = 1'b0; ceb = 1'b0; aa = '0; ab = '0; db = '0; bwb = '0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!rdy_a && n < 200) begin
            cyc();
            n++;
        end
        chk(name, DW'(n), DW'(64));
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return 64'h1111_0000_0000_0000 + DW'(i) * 64'h0000_0003_0000_0101;
    endfunction

    initial begin
        int first_v, last_v, nv;
        rst = 1'b1;
        idle();
        cyc();
        started = 1'b1;
        chk("reset_qa", qa_a, '0);
        chk("reset_ready", DW'(rdy_b), '0);
        cyc(); cyc();

        // Release; hammer CEA/CEB at address 7 during INIT
        rst = 1'b0;
        cea = 1'b1; aa = 7'(7) >> 0; ceb = 1'b1; ab = 6'd7; db = '1; bwb = '1;
        aa  = 6'd7;
        wait_ready("init_cycles");
        idle();

        // Word touched during INIT must still hold INIT_VALUE
        cea = 1'b1; aa = 6'd7;
        cyc();
        cea = 1'b0;
        chk("init_read_valid", DW'(v_a), DW'(1));
        chk("init_read_data", qa_a, INITV);
        cyc();
        chk("init_read_b", qa_b, INITV);

        // Write 5 then read 5
        ceb = 1'b1; ab = 6'd5; db = 64'hA5A5; bwb = '1;
        cyc();
        ceb = 1'b0; cea = 1'b1; aa = 6'd5;
        cyc();
        cea = 1'b0;
        chk("wr_rd_lat1_valid", DW'(v_a), DW'(1));
        chk("wr_rd_lat1_data", qa_a, 64'hA5A5);
        chk("wr_rd_lat2_early", DW'(v_b), DW'(0));
        cyc();
        chk("wr_rd_lat2_valid", DW'(v_b), DW'(1));
        chk("wr_rd_lat2_data", qa_b, 64'hA5A5);
        chk("hold_a", qa_a, 64'hA5A5);

        // Read-during-write with bit-enable merge
        ceb = 1'b1; ab = 6'd9; db = 64'hFFFF_0000; bwb = '1;
        cyc();
        db = 64'h1234_5678; bwb = 64'h0000_FFFF; cea = 1'b1; aa = 6'd9;
        cyc();
        idle();
        chk("bypass_on", qa_a, 64'hFFFF_5678);
        cyc();
        chk("bypass_off", qa_b, 64'hFFFF_0000);
        cea = 1'b1; aa = 6'd9;
        cyc();
        cea = 1'b0;
        chk("merged_stored", qa_a, 64'hFFFF_5678);
        cyc();

        // Random traffic, collisions made frequent
        for (int k = 0; k < 1500; k++) begin
            cea = 1'($urandom_range(0, 1));
            ceb = 1'($urandom_range(0, 1));
            ab  = AW'($urandom_range(0, DEPTH - 1));
            aa  = ($urandom_range(0, 2) == 0) ? ab : AW'($urandom_range(0, DEPTH - 1));
            db  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       bwb = '0;
                1:       bwb = '1;
                default: bwb = {$urandom, $urandom};
            endcase
            cyc();
        end
        idle();

        // Reset while a latency-2 read is in flight
        cea = 1'b1; aa = 6'd3;
        cyc();
        cea = 1'b0;
        rst = 1'b1;
        #1;
        chk("midread_valid_b", DW'(v_b), DW'(0));
        chk("midread_qa_b", qa_b, '0);
        cyc();
        chk("midread_after", DW'(v_b), DW'(0));
        rst = 1'b0;

        // Reset again at INIT cycle 30; init must restart from address 0
        for (int k = 0; k < 30; k++) cyc();
        chk("midinit_ready", DW'(rdy_a), DW'(0));
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        wait_ready("reinit_cycles");

        // Every word reads INIT_VALUE
        for (int k = 0; k < 65; k++) begin
            cea = (k < 64); aa = AW'(k);
            cyc();
            if (v_a) chk("reinit_word", qa_a, INITV);
        end
        idle();
        cyc(); cyc();

        // Fill with a pattern, then back-to-back reads at latency 2
        for (int k = 0; k < 64; k++) begin
            ceb = 1'b1; ab = AW'(k); db = pat(k); bwb = '1;
            cyc();
        end
        idle();
        nv = 0; first_v = -1; last_v = -1;
        for (int k = 0; k < 68; k++) begin
            cea = (k < 64); aa = AW'(k);
            cyc();
            if (v_b) begin
                chk("b2b_data", qa_b, pat(nv));
                if (first_v < 0) first_v = k;
                last_v = k;
                nv++;
            end
        end
        idle();
        chk("b2b_count", DW'(nv), DW'(64));
        chk("b2b_contiguous", DW'(last_v - first_v + 1), DW'(64));
        chk("b2b_first_cycle", DW'(first_v), DW'(1));
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
